// File: rtl/sensor_cond.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_cond
//  Description : Conditioning front end for the eBike PID loop. Synchronises
//                the cadence pulse, measures the cadence period, keeps
//                exponential averages of motor current and pedal torque,
//                derives the target current and the signed current error.
//  Revision    : 1.0  initial release
// ============================================================================
module sensor_cond #(
   parameter bit          FAST_SIM   = 1'b0,
   parameter logic [11:0] LOW_TORQUE = 12'h2C0,
   parameter logic [11:0] LOW_BATT   = 12'hA98
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cadence,
   input  logic [11:0]        curr,
   input  logic [11:0]        torque,
   input  logic [11:0]        batt,
   output logic signed [12:0] error,
   output logic               not_pedaling,
   output logic [11:0]        target_curr
);

   // Saturation value of the cadence counter; FAST_SIM uses only 15 bits.
   localparam logic [21:0] CAD_SAT = FAST_SIM ? 22'h007FFF : 22'h3FFFFF;

   logic        cad_ff1, cad_ff2, cad_ff3;
   logic        cad_rise;
   logic [21:0] smpl_cnt;
   logic        smpl_tick;
   logic [13:0] curr_accum;
   logic [16:0] torq_accum;
   logic [11:0] avg_curr;
   logic [11:0] avg_torque;
   logic [21:0] cad_cnt;
   logic [21:0] cad_per;
   logic        cad_sat_next;
   logic        first_seen;
   logic        rise_d;
   logic [1:0]  cad_scale;
   logic [12:0] torq_diff;
   logic [14:0] target_raw;
   logic        target_zero;

   // Three-flop synchroniser for the asynchronous cadence pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cad_ff1 <= 1'b0;
         cad_ff2 <= 1'b0;
         cad_ff3 <= 1'b0;
      end else begin
         cad_ff1 <= cadence;
         cad_ff2 <= cad_ff1;
         cad_ff3 <= cad_ff2;
      end
   end

   assign cad_rise = cad_ff2 & ~cad_ff3;

   // Free-running sample-rate counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) smpl_cnt <= 22'd0;
      else        smpl_cnt <= smpl_cnt + 22'd1;
   end

   assign smpl_tick = FAST_SIM ? (&smpl_cnt[14:0]) : (&smpl_cnt);

   // Current average: 3/4 decay per sample tick, 16-bit intermediate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) curr_accum <= 14'd0;
      else if (smpl_tick)
         curr_accum <= 14'((({2'b00, curr_accum} * 16'd3) >> 2) + {4'b0000, curr});
   end

   // Torque average: 31/32 decay per cadence edge, 22-bit intermediate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) torq_accum <= 17'd0;
      else if (cad_rise)
         torq_accum <= 17'((({5'b00000, torq_accum} * 22'd31) >> 5) + {10'b0, torque});
   end

   assign avg_curr   = curr_accum[13:2];
   assign avg_torque = torq_accum[16:5];

   // Cadence period counter; saturates so a stopped crank reads as "slow".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cad_cnt <= 22'd0;
         cad_per <= 22'd0;
      end else if (cad_rise) begin
         cad_cnt <= 22'd0;
         cad_per <= cad_cnt;
      end else if (cad_cnt != CAD_SAT) begin
         cad_cnt <= cad_cnt + 22'd1;
      end
   end

   // The counter holds (or is about to hold) its saturated value this cycle.
   assign cad_sat_next = ~cad_rise & ((cad_cnt == CAD_SAT) | (cad_cnt == CAD_SAT - 22'd1));

   // Track the first edge after reset; its period is measured from reset and is meaningless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_seen <= 1'b0;
         rise_d     <= 1'b0;
      end else begin
         if (cad_rise) first_seen <= 1'b1;
         rise_d <= cad_rise & first_seen;
      end
   end

   // Pedaling detector: timeout sets, a valid measured period clears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                not_pedaling <= 1'b1;
      else if (cad_sat_next)                     not_pedaling <= 1'b1;
      else if (rise_d && (cad_per != CAD_SAT))   not_pedaling <= 1'b0;
   end

   // Faster pedaling (shorter period) gives a larger gain on torque.
   assign cad_scale   = FAST_SIM ? ~cad_per[14:13] : ~cad_per[21:20];
   assign torq_diff   = {1'b0, avg_torque} - {1'b0, LOW_TORQUE};
   assign target_raw  = {3'b000, torq_diff[11:0]} << cad_scale;
   assign target_zero = not_pedaling | (batt < LOW_BATT) | torq_diff[12];

   // Target current register, clipped at zero and saturated at full scale.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               target_curr <= 12'd0;
      else if (target_zero)     target_curr <= 12'd0;
      else if (|target_raw[14:12]) target_curr <= 12'hFFF;
      else                      target_curr <= target_raw[11:0];
   end

   // Signed error handed to the PID; range fits 13 bits without saturation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) error <= 13'sd0;
      else        error <= $signed({1'b0, target_curr} - {1'b0, avg_curr});
   end

endmodule
`default_nettype wire

// File: tb/tb_sensor_cond.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sensor_cond
//  Description : Scoreboard bench for sensor_cond (FAST_SIM build) with a
//                behavioural model driven by event times.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sensor_cond;

   localparam int SAT  = 32767;
   localparam int TICK = 32768;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               cadence = 1'b0;
   logic [11:0]        curr = 12'd0;
   logic [11:0]        torque = 12'd0;
   logic [11:0]        batt = 12'd0;
   logic signed [12:0] error;
   logic               not_pedaling;
   logic [11:0]        target_curr;

   sensor_cond #(
      .FAST_SIM   (1'b1),
      .LOW_TORQUE (12'h2C0),
      .LOW_BATT   (12'hA98)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cadence      (cadence),
      .curr         (curr),
      .torque       (torque),
      .batt         (batt),
      .error        (error),
      .not_pedaling (not_pedaling),
      .target_curr  (target_curr)
   );

   always #5 clk = ~clk;

   // Cycle index: number of rising edges since reset was released.
   int cyc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   int tests = 0;
   int fails = 0;

   typedef struct {
      int          due;
      logic [12:0] err;
      logic [11:0] tgt;
      logic        np;
   } exp_t;
   exp_t sb[$];

   // ---------------- behavioural model ----------------
   int m_caccum, m_taccum, m_last_rise, m_last_per, m_ticks_upto;
   bit m_np, m_had_rise;

   function automatic void model_reset();
      m_caccum = 0; m_taccum = 0; m_last_rise = 0; m_last_per = 0;
      m_ticks_upto = 0; m_np = 1'b1; m_had_rise = 1'b0;
   endfunction

   // Apply every sample tick that lands on an edge in (m_ticks_upto, upto].
   function automatic void apply_ticks(input int upto, input int cval);
      if (upto > m_ticks_upto) begin
         int n = upto / TICK - m_ticks_upto / TICK;
         for (int k = 0; k < n; k++) m_caccum = (((m_caccum * 3) >> 2) + cval) & 'h3FFF;
         m_ticks_upto = upto;
      end
   endfunction

   // A cadence rise registered by the design on edge a.
   function automatic void model_rise(input int a, input int tq);
      int gap = a - m_last_rise - 1;
      int per = (gap > SAT) ? SAT : gap;
      if (gap >= SAT) m_np = 1'b1;
      m_taccum = (((m_taccum * 31) >> 5) + tq) & 'h1FFFF;
      if (m_had_rise && per < SAT) m_np = 1'b0;
      m_had_rise = 1'b1;
      m_last_rise = a;
      m_last_per = per;
   endfunction

   function automatic bit np_at(input int p);
      return m_np || ((p - m_last_rise) >= SAT);
   endfunction

   function automatic int tgt_at(input int p, input int bt);
      int t, sc, r;
      if (np_at(p - 1) || bt < 'hA98) return 0;
      t = (m_taccum >> 5) - 'h2C0;
      if (t < 0) t = 0;
      sc = 3 - (m_last_per >> 13);
      r = t << sc;
      if (r > 4095) r = 4095;
      return r;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic sched_check();
      exp_t e;
      int d = cyc + 2;
      apply_ticks(d - 1, int'(curr));
      e.due = d;
      e.np  = np_at(d);
      e.tgt = 12'(tgt_at(d, int'(batt)));
      e.err = 13'(tgt_at(d - 1, int'(batt)) - (m_caccum >> 2));
      sb.push_back(e);
   endtask

   task automatic pedal_edge(input int per, input logic [11:0] tq, input logic [11:0] bt,
                             input logic [11:0] cu);
      int c0 = cyc;
      apply_ticks(c0, int'(curr));
      curr = cu; torque = tq; batt = bt;
      cadence = 1'b1;
      model_rise(c0 + 3, int'(tq));
      wait_until(c0 + 4);
      cadence = 1'b0;
      wait_until(c0 + 10);
      sched_check();
      wait_until(c0 + per);
   endtask

   function automatic logic [11:0] rand_torque();
      case ($urandom_range(0, 3))
         0: return 12'h100;
         1: return 12'($urandom_range(0, 4095));
         2: return 12'(12'h2C0 + $urandom_range(0, 200));
         default: return 12'h6C0;
      endcase
   endfunction

   function automatic logic [11:0] rand_batt();
      case ($urandom_range(0, 3))
         0: return 12'hA97;
         1: return 12'hA98;
         2: return 12'hC00;
         default: return 12'($urandom_range(0, 4095));
      endcase
   endfunction

   function automatic void chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            while (sb.size() > 0 && sb[0].due <= cyc) begin
               e = sb.pop_front();
               if (e.due != cyc) begin
                  chk("sb_missed_slot", cyc, e.due);
               end else begin
                  chk("not_pedaling", int'(not_pedaling), int'(e.np));
                  chk("target_curr", int'(target_curr), int'(e.tgt));
                  chk("error", int'(error), int'($signed(e.err)));
               end
            end
         end
      end
   end

   // ---------------- main stimulus ----------------
   initial begin
      batt = 12'hC00; torque = 12'h6C0; curr = 12'h400;
      #23;
      chk("reset_error", int'(error), 0);
      chk("reset_target", int'(target_curr), 0);
      chk("reset_not_pedaling", int'(not_pedaling), 1);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      wait_until(20);
      sched_check();
      wait_until(23);

      // Steady pedaling, fast cadence, healthy battery.
      for (int i = 0; i < 40; i++) pedal_edge(64, 12'h6C0, 12'hC00, 12'h400);

      // Randomised pedaling including low battery and sub-floor torque.
      for (int i = 0; i < 50; i++)
         pedal_edge($urandom_range(20, 200), rand_torque(), rand_batt(),
                    12'($urandom_range(0, 4095)));

      // Slower cadence selects a smaller gain.
      pedal_edge(9000, 12'h400, 12'hC00, 12'($urandom_range(0, 4095)));
      pedal_edge(64, 12'h400, 12'hC00, 12'($urandom_range(0, 4095)));

      // Strong torque, then stop pedaling and watch the timeout.
      for (int i = 0; i < 5; i++) pedal_edge(100, 12'hFFF, 12'hC00, 12'h400);
      wait_until(m_last_rise + SAT - 3);
      sched_check();
      @(negedge clk);
      sched_check();
      @(negedge clk);
      sched_check();
      wait_until(cyc + 3);

      // Resume: first edge sees a saturated period, second one clears.
      while (cyc < 66000)
         pedal_edge($urandom_range(100, 400), rand_torque(), rand_batt(),
                    12'($urandom_range(0, 4095)));

      // Asynchronous reset in the middle of a cycle.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_error", int'(error), 0);
      chk("midrun_reset_target", int'(target_curr), 0);
      chk("midrun_reset_not_pedaling", int'(not_pedaling), 1);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      wait_until(20);
      sched_check();
      wait_until(25);

      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
